// File: rtl/ctrl_flow_pkg.sv
// Shared constants and types for the LC-3 control-flow sequencer.
// States, opcodes and mux encodings are fixed by the LC-3 datapath.
package ctrl_flow_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE      = 3'd0;
   localparam state_t S_DECODE    = 3'd1;
   localparam state_t S_SAVE_R7   = 3'd2;
   localparam state_t S_UPDATE_PC = 3'd3;
   localparam state_t S_DONE      = 3'd4;

   // Where DECODE sends the sequence next.
   typedef enum logic [1:0] {
      PATH_DONE   = 2'd0,
      PATH_UPDATE = 2'd1,
      PATH_SAVE   = 2'd2
   } path_e;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_JSR = 4'b0100;

   localparam logic [1:0] A2_ZERO   = 2'b00;
   localparam logic [1:0] A2_SEXT6  = 2'b01;
   localparam logic [1:0] A2_SEXT9  = 2'b10;
   localparam logic [1:0] A2_SEXT11 = 2'b11;

   localparam logic [1:0] PC_PLUS1 = 2'b00;
   localparam logic [1:0] PC_ADDER = 2'b01;
   localparam logic [1:0] PC_BUS   = 2'b10;

   localparam logic A1_PC    = 1'b0;
   localparam logic A1_BASER = 1'b1;

   // JSRR through R7 would overwrite its own target while saving the link.
   function automatic logic jsrr_r7(input logic [3:0] op, input logic jsr_mode,
                                    input logic [2:0] base_r);
      return (op == OP_JSR) && !jsr_mode && (base_r == 3'd7);
   endfunction

endpackage

// File: rtl/ctrl_flow_seq_if.sv
// Port bundle between the ISDU (master) and the control-flow sequencer (slave).
// Handshake: start is sampled only while busy=0; an accepted start raises busy on the next
// cycle and busy stays high until the cycle after the done pulse. There is no queueing.
interface ctrl_flow_seq_if;
   import ctrl_flow_pkg::*;

   logic        start;
   logic [15:0] ir;
   logic [2:0]  nzp;
   logic        busy;
   logic        done;
   logic        illegal;
   logic        taken;
   logic        addr1_sel;
   logic [1:0]  addr2_sel;
   logic [1:0]  pcmux_sel;
   logic [2:0]  sr1_sel;
   logic        gate_pc;
   logic        ld_pc;
   logic        ld_reg;
   logic [2:0]  dr_sel;
   state_t      state_dbg;
   logic [15:0] ir_dbg;

   modport master (
      output start, ir, nzp,
      input  busy, done, illegal, taken, addr1_sel, addr2_sel, pcmux_sel,
             sr1_sel, gate_pc, ld_pc, ld_reg, dr_sel, state_dbg, ir_dbg
   );

   modport slave (
      input  start, ir, nzp,
      output busy, done, illegal, taken, addr1_sel, addr2_sel, pcmux_sel,
             sr1_sel, gate_pc, ld_pc, ld_reg, dr_sel, state_dbg, ir_dbg
   );

endinterface

// File: rtl/ctrl_flow_seq_decode.sv
// Combinational decode of a latched control-flow instruction: next path,
// address-adder operand selects and the illegal flag.
module cf_decode
   import ctrl_flow_pkg::*;
(
   input  logic [15:6] ir_hi,
   input  logic [2:0]  nzp,
   output path_e       path,
   output logic        addr1_sel,
   output logic [1:0]  addr2_sel,
   output logic        illegal
);

   always_comb begin
      path      = PATH_DONE;
      addr1_sel = A1_PC;
      addr2_sel = A2_ZERO;
      illegal   = 1'b0;
      case (ir_hi[15:12])
         OP_BR: begin
            addr2_sel = A2_SEXT9;
            if ((ir_hi[11:9] & nzp) != 3'b000) path = PATH_UPDATE;
         end
         OP_JMP: begin
            addr1_sel = A1_BASER;
            path      = PATH_UPDATE;
         end
         OP_JSR: begin
            if (jsrr_r7(ir_hi[15:12], ir_hi[11], ir_hi[8:6])) begin
               illegal = 1'b1;
            end else begin
               path = PATH_SAVE;
               // ir[11] picks PC-relative JSR over register-indirect JSRR.
               if (ir_hi[11]) addr2_sel = A2_SEXT11;
               else           addr1_sel = A1_BASER;
            end
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_flow_seq.sv
// Multi-cycle sequencer for BR, JMP/RET, JSR and JSRR: owns the state register,
// the latched instruction and the taken/illegal flags; outputs are Moore.
module ctrl_flow_seq
   import ctrl_flow_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   ctrl_flow_seq_if.slave bus
);

   state_t      state_q, state_d;
   logic [15:0] ir_q;
   logic        taken_q, illegal_q;

   path_e       dec_path;
   logic        dec_addr1;
   logic [1:0]  dec_addr2;
   logic        dec_illegal;

   cf_decode u_decode (
      .ir_hi     (ir_q[15:6]),
      .nzp       (bus.nzp),
      .path      (dec_path),
      .addr1_sel (dec_addr1),
      .addr2_sel (dec_addr2),
      .illegal   (dec_illegal)
   );

   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:      state_d = bus.start ? S_DECODE : S_IDLE;
         S_DECODE: begin
            case (dec_path)
               PATH_UPDATE: state_d = S_UPDATE_PC;
               PATH_SAVE:   state_d = S_SAVE_R7;
               default:     state_d = S_DONE;
            endcase
         end
         S_SAVE_R7:   state_d = S_UPDATE_PC;
         S_UPDATE_PC: state_d = S_DONE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ir_q      <= 16'h0000;
         taken_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && bus.start) ir_q <= bus.ir;
         // nzp only matters here; the flags carry the verdict through to DONE.
         if (state_q == S_DECODE) begin
            taken_q   <= (dec_path != PATH_DONE);
            illegal_q <= dec_illegal;
         end
      end
   end

   logic       o_done, o_taken, o_illegal, o_addr1, o_gate_pc, o_ld_pc, o_ld_reg;
   logic [1:0] o_addr2, o_pcmux;
   logic [2:0] o_sr1, o_dr;

   always_comb begin
      o_done    = 1'b0;
      o_taken   = 1'b0;
      o_illegal = 1'b0;
      o_addr1   = A1_PC;
      o_addr2   = A2_ZERO;
      o_pcmux   = PC_PLUS1;
      o_sr1     = 3'd0;
      o_gate_pc = 1'b0;
      o_ld_pc   = 1'b0;
      o_ld_reg  = 1'b0;
      o_dr      = 3'd0;
      case (state_q)
         S_SAVE_R7: begin
            o_gate_pc = 1'b1;
            o_ld_reg  = 1'b1;
            o_dr      = 3'd7;
         end
         S_UPDATE_PC: begin
            o_ld_pc = 1'b1;
            o_pcmux = PC_ADDER;
            o_addr1 = dec_addr1;
            o_addr2 = dec_addr2;
            if (dec_addr1 == A1_BASER) o_sr1 = ir_q[8:6];
         end
         S_DONE: begin
            o_done    = 1'b1;
            o_taken   = taken_q;
            o_illegal = illegal_q;
         end
         default: ;
      endcase
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = o_done;
   assign bus.taken     = o_taken;
   assign bus.illegal   = o_illegal;
   assign bus.addr1_sel = o_addr1;
   assign bus.addr2_sel = o_addr2;
   assign bus.pcmux_sel = o_pcmux;
   assign bus.sr1_sel   = o_sr1;
   assign bus.gate_pc   = o_gate_pc;
   assign bus.ld_pc     = o_ld_pc;
   assign bus.ld_reg    = o_ld_reg;
   assign bus.dr_sel    = o_dr;
   assign bus.state_dbg = state_q;
   assign bus.ir_dbg    = ir_q;

endmodule
